// File: rtl/spi_arb.sv
// spi_arb: shares one SD-card SPI master and its chip-select between two
// requesters (0 = Z80 port path, 1 = boot/ROM loader). Ownership is granted
// per chip-select session; each byte is issued as a one-clock tx/rx strobe,
// timed in cen ticks, and returned to the owner with a done pulse.
module spi_arb #(
    parameter int TICKS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cen,
    input  logic       req0_cs,
    input  logic       req0_stb,
    input  logic       req0_rd,
    input  logic [7:0] req0_d,
    output logic       req0_done,
    input  logic       req1_cs,
    input  logic       req1_stb,
    input  logic       req1_rd,
    input  logic [7:0] req1_d,
    output logic       req1_done,
    output logic [7:0] q,
    output logic [1:0] owner,
    output logic       spi_tx,
    output logic       spi_rx,
    output logic [7:0] spi_d,
    input  logic [7:0] spi_q,
    output logic       sd_cs
);

    localparam int CW = $clog2(TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          pend0;
    logic          pend1;
    logic [7:0]    buf_d0;
    logic [7:0]    buf_d1;
    logic          buf_rd0;
    logic          buf_rd1;

    logic          own_cs;
    logic          own_pend;
    logic [7:0]    own_d;
    logic          own_rd;

    // Per-requester pending byte: the first strobe is kept until its ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend0   <= 1'b0;
            pend1   <= 1'b0;
            buf_d0  <= 8'h00;
            buf_d1  <= 8'h00;
            buf_rd0 <= 1'b0;
            buf_rd1 <= 1'b0;
        end else begin
            if (req0_stb && !pend0) begin
                pend0   <= 1'b1;
                buf_d0  <= req0_d;
                buf_rd0 <= req0_rd;
            end else if (state == ISSUE && owner == 2'b01) begin
                pend0 <= 1'b0;
            end
            if (req1_stb && !pend1) begin
                pend1   <= 1'b1;
                buf_d1  <= req1_d;
                buf_rd1 <= req1_rd;
            end else if (state == ISSUE && owner == 2'b10) begin
                pend1 <= 1'b0;
            end
        end
    end

    // Select the current owner's chip-select intent and pending byte.
    always_comb begin
        own_cs   = req0_cs;
        own_pend = pend0;
        own_d    = buf_d0;
        own_rd   = buf_rd0;
        if (owner == 2'b10) begin
            own_cs   = req1_cs;
            own_pend = pend1;
            own_d    = buf_d1;
            own_rd   = buf_rd1;
        end
    end

    // Session arbitration and byte sequencing; strobes and done are one-clock pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 2'b00;
            sd_cs     <= 1'b1;
            last      <= 1'b1;
            spi_tx    <= 1'b0;
            spi_rx    <= 1'b0;
            spi_d     <= 8'h00;
            q         <= 8'h00;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            cnt       <= '0;
        end else begin
            spi_tx    <= 1'b0;
            spi_rx    <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (owner != 2'b00) begin
                        if (own_cs) begin
                            owner <= 2'b00;
                            sd_cs <= 1'b1;
                        end else if (own_pend) begin
                            state  <= ISSUE;
                            spi_d  <= own_d;
                            spi_tx <= !own_rd;
                            spi_rx <= own_rd;
                        end
                    end else if (!req0_cs && !req1_cs) begin
                        if (last) begin
                            owner <= 2'b01;
                            last  <= 1'b0;
                        end else begin
                            owner <= 2'b10;
                            last  <= 1'b1;
                        end
                        sd_cs <= 1'b0;
                    end else if (!req0_cs) begin
                        owner <= 2'b01;
                        last  <= 1'b0;
                        sd_cs <= 1'b0;
                    end else if (!req1_cs) begin
                        owner <= 2'b10;
                        last  <= 1'b1;
                        sd_cs <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cen) begin
                        if (cnt == CW'(TICKS - 1)) begin
                            cnt       <= CW'(TICKS);
                            state     <= DONE;
                            q         <= spi_q;
                            req0_done <= (owner == 2'b01);
                            req1_done <= (owner == 2'b10);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed bench for spi_arb with hand-computed expectations.
module tb_spi_arb;

    logic       clock = 1'b0;
    logic       reset;
    logic       cen;
    logic       req0_cs, req0_stb, req0_rd;
    logic [7:0] req0_d;
    logic       req0_done;
    logic       req1_cs, req1_stb, req1_rd;
    logic [7:0] req1_d;
    logic       req1_done;
    logic [7:0] q;
    logic [1:0] owner;
    logic       spi_tx, spi_rx;
    logic [7:0] spi_d;
    logic [7:0] spi_q;
    logic       sd_cs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cen_div = 1;
    int ntx, nrx, nd0, nd1, viol;
    int tx_cyc, rx_cyc, d0_cyc, d1_cyc, stb_cyc;
    logic [7:0] tx_d, d0_q, d1_q;
    logic       d0_sdcs;

    spi_arb #(.TICKS(16)) dut (
        .clock(clock), .reset(reset), .cen(cen),
        .req0_cs(req0_cs), .req0_stb(req0_stb), .req0_rd(req0_rd),
        .req0_d(req0_d), .req0_done(req0_done),
        .req1_cs(req1_cs), .req1_stb(req1_stb), .req1_rd(req1_rd),
        .req1_d(req1_d), .req1_done(req1_done),
        .q(q), .owner(owner), .spi_tx(spi_tx), .spi_rx(spi_rx),
        .spi_d(spi_d), .spi_q(spi_q), .sd_cs(sd_cs)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        cen = (cen_div <= 1) ? 1'b1 : (((cyc % cen_div) == 0) ? 1'b1 : 1'b0);
        if (spi_tx === 1'b1) begin ntx++; tx_cyc = cyc; tx_d = spi_d; end
        if (spi_rx === 1'b1) begin nrx++; rx_cyc = cyc; end
        if (req0_done === 1'b1) begin nd0++; d0_cyc = cyc; d0_q = q; d0_sdcs = sd_cs; end
        if (req1_done === 1'b1) begin nd1++; d1_cyc = cyc; d1_q = q; end
        if (spi_tx === 1'b1 && spi_rx === 1'b1) viol++;
        if (owner == 2'b00 && sd_cs !== 1'b1) viol++;
        if (owner == 2'b11) viol++;
    endtask

    task automatic clearRec();
        ntx = 0; nrx = 0; nd0 = 0; nd1 = 0;
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] d, input logic rd);
        stb_cyc = cyc;
        if (which == 0) begin req0_stb = 1'b1; req0_d = d; req0_rd = rd; end
        else begin req1_stb = 1'b1; req1_d = d; req1_rd = rd; end
        step();
        req0_stb = 1'b0;
        req1_stb = 1'b0;
    endtask

    function automatic int evCount(input int which);
        case (which)
            0: return nd0;
            1: return nd1;
            default: return ntx + nrx;
        endcase
    endfunction

    task automatic waitFor(input int which, input int budget, input string tag);
        int start;
        start = evCount(which);
        for (int i = 0; i < budget && evCount(which) == start; i++) step();
        checkOutput(tag, (evCount(which) > start) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req0_cs = 1'b1; req1_cs = 1'b1;
        req0_stb = 1'b0; req1_stb = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; cen = 1'b1; spi_q = 8'h00;
        req0_cs = 1'b1; req0_stb = 1'b0; req0_rd = 1'b0; req0_d = 8'h00;
        req1_cs = 1'b1; req1_stb = 1'b0; req1_rd = 1'b0; req1_d = 8'h00;
        viol = 0; clearRec();
        step(); step();
        reset = 1'b0;
        step();
        checkOutput("reset owner", owner, 0);
        checkOutput("reset sd_cs", sd_cs, 1);
        checkOutput("reset q", q, 0);
        checkOutput("reset spi_d", spi_d, 0);
        checkOutput("reset strobes", {spi_tx, spi_rx, req0_done, req1_done}, 0);

        // Single-owner transmit from requester 0.
        clearRec();
        req0_cs = 1'b0;
        step();
        checkOutput("t1 owner", owner, 1);
        checkOutput("t1 sd_cs", sd_cs, 0);
        applyStimulus(0, 8'hA5, 1'b0);
        waitFor(0, 100, "t1 done timeout");
        step(); step(); step();
        checkOutput("t1 tx count", ntx, 1);
        checkOutput("t1 spi_d", tx_d, 8'hA5);
        checkOutput("t1 rx count", nrx, 0);
        checkOutput("t1 issue latency", tx_cyc - stb_cyc, 2);
        checkOutput("t1 done latency", d0_cyc - tx_cyc, 17);
        checkOutput("t1 done count", nd0, 1);
        checkOutput("t1 req1 done", nd1, 0);

        // Receive path from requester 1 with a slower cen.
        req0_cs = 1'b1;
        step(); step();
        checkOutput("t2 release owner", owner, 0);
        checkOutput("t2 release sd_cs", sd_cs, 1);
        clearRec();
        req1_cs = 1'b0;
        spi_q = 8'h3C;
        step();
        checkOutput("t2 owner", owner, 2);
        cen_div = 2;
        applyStimulus(1, 8'h00, 1'b1);
        waitFor(1, 200, "t2 done timeout");
        cen_div = 1;
        checkOutput("t2 q", d1_q, 8'h3C);
        checkOutput("t2 tx count", ntx, 0);
        checkOutput("t2 rx count", nrx, 1);
        checkOutput("t2 req0 done", nd0, 0);
        req1_cs = 1'b1;
        step(); step();

        // Contention right after reset, then round-robin.
        doReset();
        req0_cs = 1'b0; req1_cs = 1'b0;
        step();
        checkOutput("t3 first owner", owner, 1);
        req0_cs = 1'b1; req1_cs = 1'b1;
        step(); step();
        checkOutput("t3 released", owner, 0);
        req0_cs = 1'b0; req1_cs = 1'b0;
        step();
        checkOutput("t3 rr owner", owner, 2);
        checkOutput("t3 rr sd_cs", sd_cs, 0);
        req0_cs = 1'b1; req1_cs = 1'b1;
        step(); step();

        // Requester 1 blocked while requester 0 owns the bus.
        clearRec();
        req0_cs = 1'b0;
        step();
        applyStimulus(0, 8'h5A, 1'b0);
        repeat (5) step();
        req1_cs = 1'b0;
        applyStimulus(1, 8'h11, 1'b0);
        waitFor(0, 100, "t4 req0 done timeout");
        repeat (5) step();
        checkOutput("t4 no req1 done", nd1, 0);
        checkOutput("t4 owner held", owner, 1);
        checkOutput("t4 single issue", ntx, 1);
        req0_cs = 1'b1;
        waitFor(1, 100, "t4 req1 done timeout");
        checkOutput("t4 req1 spi_d", tx_d, 8'h11);
        checkOutput("t4 tx count", ntx, 2);
        checkOutput("t4 req1 latency", d1_cyc - tx_cyc, 17);
        checkOutput("t4 owner req1", owner, 2);
        req1_cs = 1'b1;
        step(); step();

        // Owner releases chip-select during WAIT.
        clearRec();
        req0_cs = 1'b0;
        step();
        applyStimulus(0, 8'h77, 1'b0);
        waitFor(2, 20, "t5 issue timeout");
        repeat (5) step();
        req0_cs = 1'b1;
        waitFor(0, 100, "t5 done timeout");
        checkOutput("t5 sd_cs at done", d0_sdcs, 0);
        step();
        checkOutput("t5 sd_cs in idle", sd_cs, 0);
        step();
        checkOutput("t5 sd_cs released", sd_cs, 1);
        checkOutput("t5 owner released", owner, 0);

        // Reset in the middle of a transfer, then a fresh receive.
        clearRec();
        req0_cs = 1'b0;
        step();
        applyStimulus(0, 8'h42, 1'b0);
        waitFor(2, 20, "t6 issue timeout");
        repeat (4) step();
        reset = 1'b1;
        #2;
        checkOutput("t6 reset sd_cs", sd_cs, 1);
        checkOutput("t6 reset owner", owner, 0);
        step();
        reset = 1'b0;
        repeat (40) step();
        checkOutput("t6 no done", nd0, 0);
        checkOutput("t6 regrant", owner, 1);
        spi_q = 8'hE1;
        applyStimulus(0, 8'h99, 1'b1);
        waitFor(0, 100, "t6 fresh done timeout");
        checkOutput("t6 fresh q", d0_q, 8'hE1);
        checkOutput("t6 fresh latency", d0_cyc - rx_cyc, 17);

        checkOutput("invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Shares the single SD-card SPI master and its chip-select between two requesters.
- Requester 0 is the Z80 port path (the E7h/EBh decode). Requester 1 is the hardware boot/ROM loader.
- Grants ownership per chip-select session, never per byte, and sequences each byte transfer: issues the tx/rx strobe, times completion in cen ticks, returns the byte with a done pulse.
- Sits between the port decoders and the spi core; drives the card's cs directly.

Parameters:
- TICKS, 16, number of cen pulses one byte transfer occupies in the spi core (8 bits x 2 edges).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cen  in  1  spi clock-enable, identical to the one feeding the spi core.
- req0_cs  in  1  requester 0 chip-select intent, active-low level.
- req0_stb  in  1  requester 0 one-clock byte-start pulse.
- req0_rd  in  1  1 = receive strobe (rx), 0 = transmit strobe (tx).
- req0_d  in  8  requester 0 byte to send.
- req0_done  out  1  one-clock pulse when requester 0's byte completes.
- req1_cs, req1_stb, req1_rd, req1_d, req1_done: same as requester 0, for requester 1.
- q  out  8  last received byte, shared by both requesters, valid from the done pulse.
- owner  out  2  00 none, 01 req0, 10 req1.
- spi_tx  out  1  one-clock transmit strobe to spi core.
- spi_rx  out  1  one-clock receive strobe to spi core.
- spi_d  out  8  byte to spi core.
- spi_q  in  8  byte from spi core.
- sd_cs  out  1  card chip-select, active-low.

Behaviour:
- Reset state:
  - State IDLE, owner 00, sd_cs 1.
  - spi_tx, spi_rx, req0_done and req1_done all 0.
  - q 00h, spi_d 00h, both pending flags 0, last-granted = req1.
- Pending flags:
  - reqN_stb sets pendN and latches reqN_d and reqN_rd into a per-requester buffer, regardless of ownership.
  - A stb while pendN is already set is ignored; the first byte is kept.
- State machine (IDLE, ISSUE, WAIT, DONE):
  - IDLE, ownership rules:
    - Owned and owner's cs = 1: release; owner becomes 00 and sd_cs becomes 1 next clock.
    - Owner 00 and exactly one reqN_cs = 0: grant N; owner updates and sd_cs = 0 next clock.
    - Owner 00 and both reqN_cs = 0: grant the requester that is not last-granted, then update last-granted.
  - IDLE, byte issue: if owned, owner's cs = 0 and owner's pend set, go to ISSUE.
  - Grant and the first issue cannot happen in the same cycle. ISSUE follows grant by at least 1 clock, so cs falls before SCK starts.
  - ISSUE, one clock:
    - Drive spi_d from the owner's buffer.
    - Assert spi_tx if rd = 0, otherwise spi_rx, for exactly this clock.
    - Clear the owner's pend and reset the tick counter; go to WAIT.
  - WAIT: count cen pulses. On the TICKS-th cen go to DONE.
  - DONE, one clock: q <= spi_q; pulse the owner's done; go to IDLE.
- Latency: owner stb at clock N with cs already granted gives ISSUE at N+2, then WAIT, then done one clock after the TICKS-th cen.
- Boundary conditions:
  - Non-owner stb: stays pending; it is served only after that requester gains ownership. Its done never fires while it does not own the bus.
  - Owner raises cs during WAIT: the transfer completes and done pulses. sd_cs stays 0 until the release in the following IDLE.
  - stb arriving in the same clock as the DONE pulse: sets pend and is served from the next IDLE.
  - cen high during ISSUE: not counted.
  - Reset mid-transfer: immediate return to reset state; sd_cs 1, no done pulse.
- Widths and invariants:
  - Tick counter is wide enough to hold TICKS and does not wrap; it saturates into DONE.
  - Only one of spi_tx and spi_rx is ever high, and only in ISSUE.
  - sd_cs equals 1 whenever owner = 00.

Test Plan:
- Single-owner tx: TICKS=16. req0_cs=0, then stb with d=A5h, rd=0.
  - owner=01 and sd_cs=0; one spi_tx pulse with spi_d=A5h.
  - req0_done exactly 1 clock after the 16th cen; req1_done stays 0.
- Rx path: spi model returns 3Ch on an rd=1 stb from req1 (owner 10) -> q=3Ch at the req1_done pulse; spi_tx never high.
- Contention: both cs fall in the same clock after reset.
  - owner=01 first.
  - After req0_cs rises and both drop again, owner=10 (round-robin).
- Blocked requester: req0 owns and is mid-transfer; req1 stb d=11h.
  - No req1_done while req0 owns.
  - After req0 releases and req1_cs=0: ISSUE with spi_d=11h, then req1_done.
- Release during transfer: req0 raises cs in WAIT -> req0_done still pulses; sd_cs returns to 1 the clock after the next IDLE evaluation.
- Reset in WAIT: assert reset -> sd_cs=1, owner=00, no done pulse. The next fresh transfer completes normally.
